// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, port count and the packed request
// that the arbiter muxes into the single ALU instance.
package alu_pkg;

   localparam int NUM_ALU_PORTS = 2;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_SLT  = 4'h2,
      ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_OR   = 4'h5,
      ALU_AND  = 4'h6,
      ALU_SLL  = 4'h7,
      ALU_SRL  = 4'h8,
      ALU_SRA  = 4'h9,
      ALU_PASB = 4'hA
   } alu_op_e;

   typedef struct packed {
      logic [31:0] operand_a;
      logic [31:0] operand_b;
      alu_op_e     alu_op;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU; unassigned opcodes yield zero.
module alu
   import alu_pkg::*;
(
   input  alu_req_t    req_i,
   output logic [31:0] result_o
);

   logic [31:0] a, b;
   logic [4:0]  shamt;

   assign a     = req_i.operand_a;
   assign b     = req_i.operand_b;
   assign shamt = b[4:0];

   always_comb begin
      result_o = '0;
      case (req_i.alu_op)
         ALU_ADD:  result_o = a + b;
         ALU_SUB:  result_o = a - b;
         ALU_SLT:  result_o = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result_o = {31'b0, a < b};
         ALU_XOR:  result_o = a ^ b;
         ALU_OR:   result_o = a | b;
         ALU_AND:  result_o = a & b;
         ALU_SLL:  result_o = a << shamt;
         ALU_SRL:  result_o = a >> shamt;
         ALU_SRA:  result_o = $unsigned($signed(a) >>> shamt);
         ALU_PASB: result_o = b;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a
// single-entry registered response slot that supports backpressure.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TAG_W = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_ALU_PORTS-1:0] i_req_valid,
   output logic [NUM_ALU_PORTS-1:0] o_req_ready,
   input  logic [31:0]              i_req0_operand_a,
   input  logic [31:0]              i_req0_operand_b,
   input  logic [31:0]              i_req1_operand_a,
   input  logic [31:0]              i_req1_operand_b,
   input  logic [3:0]               i_req0_alu_op,
   input  logic [3:0]               i_req1_alu_op,
   input  logic [TAG_W-1:0]         i_req0_tag,
   input  logic [TAG_W-1:0]         i_req1_tag,
   output logic [NUM_ALU_PORTS-1:0] o_rsp_valid,
   input  logic [NUM_ALU_PORTS-1:0] i_rsp_ready,
   output logic [31:0]              o_rsp0_data,
   output logic [31:0]              o_rsp1_data,
   output logic [TAG_W-1:0]         o_rsp0_tag,
   output logic [TAG_W-1:0]         o_rsp1_tag,
   output logic                     o_last_grant
);

   alu_req_t                 req [NUM_ALU_PORTS];
   logic [TAG_W-1:0]         tag [NUM_ALU_PORTS];
   logic [NUM_ALU_PORTS-1:0] eligible, grant;
   alu_req_t                 alu_req;
   logic [31:0]              alu_result;

   logic [NUM_ALU_PORTS-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]              rsp_data_q [NUM_ALU_PORTS];
   logic [31:0]              rsp_data_d [NUM_ALU_PORTS];
   logic [TAG_W-1:0]         rsp_tag_q [NUM_ALU_PORTS];
   logic [TAG_W-1:0]         rsp_tag_d [NUM_ALU_PORTS];
   logic                     last_grant_q, last_grant_d;

   assign req[0] = '{i_req0_operand_a, i_req0_operand_b, alu_op_e'(i_req0_alu_op)};
   assign req[1] = '{i_req1_operand_a, i_req1_operand_b, alu_op_e'(i_req1_alu_op)};
   assign tag[0] = i_req0_tag;
   assign tag[1] = i_req1_tag;

   // A slot draining this cycle counts as free, so a port can refill back-to-back.
   assign eligible = i_req_valid & (~rsp_valid_q | i_rsp_ready);

   always_comb begin
      grant = eligible;
      if (&eligible) begin
         grant = last_grant_q ? 2'b01 : 2'b10;
      end
   end

   assign o_req_ready = grant;
   assign alu_req     = grant[1] ? req[1] : req[0];

   alu u_alu (
      .req_i    (alu_req),
      .result_o (alu_result)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_tag_d    = rsp_tag_q;
      last_grant_d = last_grant_q;
      for (int p = 0; p < NUM_ALU_PORTS; p++) begin
         if (grant[p]) begin
            rsp_valid_d[p] = 1'b1;
            rsp_data_d[p]  = alu_result;
            rsp_tag_d[p]   = tag[p];
         end else if (i_rsp_ready[p]) begin
            rsp_valid_d[p] = 1'b0;
         end
      end
      if (|grant) begin
         last_grant_d = grant[1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_q  <= '0;
         rsp_data_q   <= '{default: '0};
         rsp_tag_q    <= '{default: '0};
         last_grant_q <= 1'b1;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_tag_q    <= rsp_tag_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp0_data  = rsp_data_q[0];
   assign o_rsp1_data  = rsp_data_q[1];
   assign o_rsp0_tag   = rsp_tag_q[0];
   assign o_rsp1_tag   = rsp_tag_q[1];
   assign o_last_grant = last_grant_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares one combinational ALU between two requesters, e.g. the integer pipe and the address/branch-compare helper. Each requester issues operand/opcode transactions over a valid/ready handshake. The block grants at most one request per cycle, evaluates it on a single internal ALU instance, and returns the registered result on that requester's own response channel, which supports backpressure. It sits between the issue logic and the shared ALU and replaces direct ALU wiring when two consumers need it.

## Interface
- TAG_W, default 2: width of the opaque tag carried from request to response.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  2  per-port request valid; bit p belongs to port p.
- o_req_ready  out  2  per-port request accept (grant).
- i_req0_operand_a, i_req0_operand_b  in  32  port 0 operands.
- i_req1_operand_a, i_req1_operand_b  in  32  port 1 operands.
- i_req0_alu_op, i_req1_alu_op  in  4  ALU opcode per port.
- i_req0_tag, i_req1_tag  in  TAG_W  per-port tag.
- o_rsp_valid  out  2  per-port response valid.
- i_rsp_ready  in  2  per-port response accept.
- o_rsp0_data, o_rsp1_data  out  32  registered ALU results.
- o_rsp0_tag, o_rsp1_tag  out  TAG_W  tags echoed from the accepted request.
- o_last_grant  out  1  port index of the most recent grant (debug/perf).

## Operation
- **Opcodes:** 0x0 add, 0x1 sub, 0x2 slt, 0x3 sltu, 0x4 xor, 0x5 or, 0x6 and, 0x7 sll, 0x8 srl, 0x9 sra, 0xA pass B. 0xB–0xF produce 0.
- **Response slot:** each port p has one slot holding valid, data and tag. The slot is free when o_rsp_valid[p]=0, or when it drains this cycle (o_rsp_valid[p] && i_rsp_ready[p]).
- **Eligibility:** port p is eligible when i_req_valid[p]=1 and its slot is free.
- **Grant:**
  - One port eligible: that port wins.
  - Both eligible: the port ≠ o_last_grant wins (round robin).
  - Neither eligible: no grant.
  - o_req_ready = one-hot grant, or 0.
- **Pointer update:** o_last_grant updates only on a grant.
- **Datapath:** the winner's operands and opcode are muxed into the single ALU. On the grant edge, the winner's slot loads the ALU result and tag and sets o_rsp_valid[p]=1.
- **Response hold:** the slot holds data and tag stable until i_rsp_ready[p]=1. It then clears valid, unless refilled by a new grant in the same cycle, in which case valid stays 1 with the new data.
- **Simultaneous drain and grant on the same port:** the new result overwrites. There is no bubble and nothing is lost.
- **Requester rule:** a request with valid=1 and ready=0 must hold its operands, opcode and tag stable. The arbiter does not latch ungranted requests.
- **Reset:**
  - Values: o_rsp_valid=0, o_rsp*_data=0, o_rsp*_tag=0, o_last_grant=1, so port 0 wins the first contention.
  - Reset asserted mid-operation discards pending responses immediately; no partial state remains.

## Timing
- **Latency:** a request accepted at edge N has its response visible after edge N, i.e. o_rsp_valid high in cycle N+1.
- **Throughput:** 1 grant per cycle in aggregate. A single port with i_rsp_ready held high sustains 1 per cycle.
- **Combinational paths:**
  - o_req_ready depends combinationally on i_req_valid, slot state and i_rsp_ready.
  - Permitted path: i_rsp_ready → o_req_ready.
  - No path from i_req_valid to o_rsp_*.
- **Fairness:** under continuous contention with both slots draining every cycle, grants alternate 0,1,0,1… Maximum wait for an eligible port is 1 cycle.
- **Blocked slot:** a port whose slot is full and not draining is never granted. The other port may then take every cycle.

## Structure
- **Shared package `alu_pkg`:**
  - typedef of the 4-bit alu_op enum with the encodings above.
  - Constant NUM_ALU_PORTS=2.
  - Packed request struct: operand_a, operand_b, alu_op.
- **Sub-module:** exactly one instance of the existing alu module, driven by the grant mux.
- **Arbiter logic:** eligibility, round-robin pointer and response slots stay in this module; no separate sub-module.

## Test plan
- **Single request:** reset, then port 0 only: a=5, b=3, op=0x1, tag=2.
  - Expect o_req_ready=01 that cycle, o_rsp_valid[0]=1 next cycle, data=2, tag=2; data held while i_rsp_ready[0]=0.
- **Contention:** both ports valid every cycle, rsp_ready=11. Port 0: a=0xFFFFFFFF, b=1, op=0x2. Port 1: same operands, op=0x3.
  - Expect grants in order 0,1,0,1. Port 0 data=1 (signed −1<1); port 1 data=0.
- **Backpressure:** port 1 i_rsp_ready=0 with its slot full, both ports requesting.
  - Expect port 0 granted every cycle and port 1 ready=0 until port 1 is drained. Then port 1 is granted the next cycle.
- **Drain+refill:** port 0 slot full, i_rsp_ready[0]=1 and a new request a=0x80000000, b=4, op=0x9 in the same cycle.
  - Expect ready=1 and the next response data=0xF8000000 with no bubble.
- **Reset mid-operation:** responses pending on both ports, assert i_rst_n=0 asynchronously between edges.
  - Expect o_rsp_valid=00, data/tags=0 and o_last_grant=1 immediately. The first contention after release grants port 0.
- **Illegal opcode:** op=0xC, a=7, b=9.
  - Expect response data=0 with the tag echoed.
